// File: rtl/conv_sched.sv
// conv_sched: raster-order 3x3 convolution tap sequencer with a delayed layer-0 write path,
// followed by an optional 2x2 max-pool pass over layer memory (enabled by `define CONV_SCHED_POOL_EN).
module conv_sched #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int ADDR_W = 12,
    parameter int WR_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ready,
    input  logic              hold,
    output logic              busy,
    output logic [ADDR_W-1:0] iaddr,
    output logic              tap_vld,
    output logic [3:0]        tap_idx,
    output logic              tap_pad,
    output logic              acc_first,
    output logic [ADDR_W-1:0] caddr_wr,
    output logic              cwr,
    output logic [ADDR_W-1:0] caddr_rd,
    output logic              crd,
    output logic [2:0]        csel,
    output logic              pool_first,
    output logic [2:0]        dbg_state
);

    // Handshake: `ready` is a level start request sampled only in IDLE; `busy` rises on the start
    // edge and falls when DONE is left. `hold` stalls every working state for the cycle it is
    // sampled: counters and the write delay line freeze and all strobes read 0 one cycle later.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CONV  = 3'd1,
        S_FLUSH = 3'd2,
        S_POOL  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0]     C_LAST   = CW'(IMG_W - 1);
    localparam logic [RW-1:0]     R_LAST   = RW'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

    state_t            state;
    logic [RW-1:0]     r;
    logic [CW-1:0]     c;
    logic [3:0]        k;
    logic [1:0]        ky, kx;
    logic [ADDR_W-1:0] center, nbr, tap_addr;
    logic              pad, last_pixel, dl_drains;

    logic [WR_LAT-1:0] dl_vld;
    logic [ADDR_W-1:0] dl_addr [WR_LAT];

    assign dbg_state = state;

    always_comb begin
        ky = 2'd0;
        kx = 2'd0;
        if (k >= 4'd6) begin
            ky = 2'd2;
            kx = 2'(k - 4'd6);
        end else if (k >= 4'd3) begin
            ky = 2'd1;
            kx = 2'(k - 4'd3);
        end else begin
            kx = 2'(k);
        end
    end

    // Padded taps point at the centre pixel so the address never wraps past the image edges.
    assign center     = ADDR_W'(r) * ROW_STEP + ADDR_W'(c);
    assign nbr        = center + ADDR_W'(ky) * ROW_STEP + ADDR_W'(kx) - ROW_STEP - ADDR_W'(1);
    assign pad        = (ky == 2'd0 && r == '0) || (ky == 2'd2 && r == R_LAST) ||
                        (kx == 2'd0 && c == '0) || (kx == 2'd2 && c == C_LAST);
    assign tap_addr   = pad ? center : nbr;
    assign last_pixel = (r == R_LAST) && (c == C_LAST);

    // True when the shift that happens this cycle leaves the delay line empty.
    always_comb begin
        dl_drains = 1'b1;
        for (int i = 0; i < WR_LAT - 1; i++) begin
            if (dl_vld[i]) dl_drains = 1'b0;
        end
    end

`ifdef CONV_SCHED_POOL_EN
    localparam int PRW = $clog2(IMG_H / 2);
    localparam int PCW = $clog2(IMG_W / 2);
    localparam logic [PRW-1:0] PR_LAST = PRW'(IMG_H / 2 - 1);
    localparam logic [PCW-1:0] PC_LAST = PCW'(IMG_W / 2 - 1);

    logic [PRW-1:0]    pr;
    logic [PCW-1:0]    pc;
    logic [2:0]        ph;
    logic [ADDR_W-1:0] pool_rd_addr, pool_wr_addr;
    logic              pool_last;

    // Phases 0..3 visit the 2x2 block as (0,0),(0,1),(1,0),(1,1): ph[1] is the row, ph[0] the column.
    assign pool_rd_addr = ADDR_W'(pr) * ADDR_W'(2 * IMG_W) + ADDR_W'(ph[1]) * ROW_STEP +
                          (ADDR_W'(pc) << 1) + ADDR_W'(ph[0]);
    assign pool_wr_addr = ADDR_W'(pr) * ADDR_W'(IMG_W / 2) + ADDR_W'(pc);
    assign pool_last    = (pr == PR_LAST) && (pc == PC_LAST);
`else
    assign crd        = 1'b0;
    assign caddr_rd   = '0;
    assign pool_first = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            iaddr     <= '0;
            tap_vld   <= 1'b0;
            tap_idx   <= 4'd0;
            tap_pad   <= 1'b0;
            acc_first <= 1'b0;
            caddr_wr  <= '0;
            cwr       <= 1'b0;
            csel      <= 3'b000;
            r         <= '0;
            c         <= '0;
            k         <= 4'd0;
            dl_vld    <= '0;
            for (int i = 0; i < WR_LAT; i++) dl_addr[i] <= '0;
`ifdef CONV_SCHED_POOL_EN
            caddr_rd   <= '0;
            crd        <= 1'b0;
            pool_first <= 1'b0;
            pr         <= '0;
            pc         <= '0;
            ph         <= 3'd0;
`endif
        end else begin
            tap_vld   <= 1'b0;
            acc_first <= 1'b0;
            cwr       <= 1'b0;
`ifdef CONV_SCHED_POOL_EN
            crd        <= 1'b0;
            pool_first <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    csel <= 3'b000;
                    if (ready) begin
                        state <= S_CONV;
                        busy  <= 1'b1;
                        csel  <= 3'b001;
                        r     <= '0;
                        c     <= '0;
                        k     <= 4'd0;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    csel  <= 3'b000;
                    state <= S_IDLE;
                end
                default: begin
                    csel <= 3'b001;
                    if (!hold) begin
                        dl_vld[0]  <= (state == S_CONV) && (k == 4'd8);
                        dl_addr[0] <= center;
                        for (int i = 1; i < WR_LAT; i++) begin
                            dl_vld[i]  <= dl_vld[i-1];
                            dl_addr[i] <= dl_addr[i-1];
                        end
                        if (dl_vld[WR_LAT-1]) begin
                            cwr      <= 1'b1;
                            caddr_wr <= dl_addr[WR_LAT-1];
                        end
                        case (state)
                            S_CONV: begin
                                tap_vld   <= 1'b1;
                                iaddr     <= tap_addr;
                                tap_idx   <= k;
                                tap_pad   <= pad;
                                acc_first <= (k == 4'd0);
                                if (k == 4'd8) begin
                                    k <= 4'd0;
                                    if (last_pixel) begin
                                        state <= S_FLUSH;
                                    end else if (c == C_LAST) begin
                                        c <= '0;
                                        r <= r + 1'b1;
                                    end else begin
                                        c <= c + 1'b1;
                                    end
                                end else begin
                                    k <= k + 4'd1;
                                end
                            end
                            S_FLUSH: begin
                                if (dl_drains) begin
`ifdef CONV_SCHED_POOL_EN
                                    state <= S_POOL;
                                    pr    <= '0;
                                    pc    <= '0;
                                    ph    <= 3'd0;
`else
                                    state <= S_DONE;
`endif
                                end
                            end
`ifdef CONV_SCHED_POOL_EN
                            S_POOL: begin
                                if (ph == 3'd4) begin
                                    cwr      <= 1'b1;
                                    csel     <= 3'b011;
                                    caddr_wr <= pool_wr_addr;
                                    ph       <= 3'd0;
                                    if (pool_last) begin
                                        state <= S_DONE;
                                    end else if (pc == PC_LAST) begin
                                        pc <= '0;
                                        pr <= pr + 1'b1;
                                    end else begin
                                        pc <= pc + 1'b1;
                                    end
                                end else begin
                                    crd        <= 1'b1;
                                    caddr_rd   <= pool_rd_addr;
                                    pool_first <= (ph == 3'd0);
                                    ph         <= ph + 3'd1;
                                end
                            end
`endif
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_sched.sv
// tb_conv_sched: scoreboard bench for conv_sched; a reference model expands the whole layer
// pass into expected tap, write and read streams that a negedge monitor consumes.
module tb_conv_sched;

    localparam int W    = 64;
    localparam int H    = 64;
    localparam int AW   = 12;
    localparam int LAT  = 2;
    localparam int NPIX = W * H;
`ifdef CONV_SCHED_POOL_EN
    localparam int BASE = NPIX * 9 + LAT + (NPIX / 4) * 5 + 1;
`else
    localparam int BASE = NPIX * 9 + LAT + 1;
`endif

    logic          clk = 1'b0;
    logic          reset, ready, hold;
    logic          busy, tap_vld, tap_pad, acc_first, cwr, crd, pool_first;
    logic [AW-1:0] iaddr, caddr_wr, caddr_rd;
    logic [3:0]    tap_idx;
    logic [2:0]    csel, dbg_state;

    conv_sched #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .WR_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .ready(ready), .hold(hold), .busy(busy),
        .iaddr(iaddr), .tap_vld(tap_vld), .tap_idx(tap_idx), .tap_pad(tap_pad),
        .acc_first(acc_first), .caddr_wr(caddr_wr), .cwr(cwr), .caddr_rd(caddr_rd),
        .crd(crd), .csel(csel), .pool_first(pool_first), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [17:0] tap_q[$];  // {acc_first, iaddr, tap_pad, tap_idx}
    logic [14:0] wr_q[$];   // {csel, caddr_wr}
    logic [15:0] rd_q[$];   // {csel, pool_first, caddr_rd}
    int          lat_q[$];  // active-cycle index at which each layer-0 write is due
    int          errors = 0;
    int          checks = 0;
    bit          mon_en = 1'b0;
    logic        hold_seen = 1'b0;
    int          act_idx = 0;
    int          busy_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_iaddr"}, iaddr, 0);
        check({tag, "_tap_vld"}, tap_vld, 0);
        check({tag, "_tap_idx"}, tap_idx, 0);
        check({tag, "_tap_pad"}, tap_pad, 0);
        check({tag, "_acc_first"}, acc_first, 0);
        check({tag, "_caddr_wr"}, caddr_wr, 0);
        check({tag, "_cwr"}, cwr, 0);
        check({tag, "_caddr_rd"}, caddr_rd, 0);
        check({tag, "_crd"}, crd, 0);
        check({tag, "_csel"}, csel, 0);
        check({tag, "_pool_first"}, pool_first, 0);
        check({tag, "_state"}, dbg_state, 0);
    endtask

    // Reference model: whole-layer streams from the raster/tap and pooling rules.
    task automatic gen_expected();
        tap_q.delete();
        wr_q.delete();
        rd_q.delete();
        lat_q.delete();
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                for (int k = 0; k < 9; k++) begin
                    int rr, cc, a;
                    bit pad;
                    rr  = r + k / 3 - 1;
                    cc  = c + k % 3 - 1;
                    pad = (rr < 0) || (rr >= H) || (cc < 0) || (cc >= W);
                    a   = pad ? r * W + c : rr * W + cc;
                    tap_q.push_back({(k == 0), AW'(a), pad, 4'(k)});
                end
                wr_q.push_back({3'b001, AW'(r * W + c)});
            end
        end
`ifdef CONV_SCHED_POOL_EN
        for (int pr = 0; pr < H / 2; pr++) begin
            for (int pc = 0; pc < W / 2; pc++) begin
                for (int i = 0; i < 2; i++) begin
                    for (int j = 0; j < 2; j++) begin
                        rd_q.push_back({3'b001, (i == 0 && j == 0), AW'((2 * pr + i) * W + 2 * pc + j)});
                    end
                end
                wr_q.push_back({3'b011, AW'(pr * (W / 2) + pc)});
            end
        end
`endif
    endtask

    always @(posedge clk) hold_seen <= hold;

    // Monitor: pops the expected streams whenever the DUT presents a strobe.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [17:0] te;
            logic [14:0] we;
            logic [15:0] re;
            int          due;
            if (!hold_seen) act_idx++;
            if (busy) busy_cnt++;
            if (hold_seen) check("held_strobes", {tap_vld, cwr, crd, pool_first}, 0);
            if (tap_vld) begin
                if (tap_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL tap_extra: got iaddr %0d idx %0d expected no tap", iaddr, tap_idx);
                end else begin
                    te = tap_q.pop_front();
                    check("tap", {acc_first, iaddr, tap_pad, tap_idx}, te);
                    if (te[3:0] == 4'd8) lat_q.push_back(act_idx + LAT);
                end
            end
            if (cwr) begin
                if (wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wr_extra: got addr %0d csel %0b expected no write", caddr_wr, csel);
                end else begin
                    we = wr_q.pop_front();
                    check("wr", {csel, caddr_wr}, we);
                    if (we[14:12] == 3'b001) begin
                        if (lat_q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL wr_lat: got write at %0d expected none pending", act_idx);
                        end else begin
                            due = lat_q.pop_front();
                            check("wr_lat", act_idx, due);
                        end
                    end
                end
            end
            if (crd) begin
                if (rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_extra: got addr %0d expected no read", caddr_rd);
                end else begin
                    re = rd_q.pop_front();
                    check("rd", {csel, pool_first, caddr_rd}, re);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int progressed, bubbles, burst_left;
        bit burst_done, h;
        reset = 1'b1;
        ready = 1'b0;
        hold  = 1'b0;
        repeat (3) step();
        check_reset("por");
        reset = 1'b0;

        // Partial run, then reset while pixel (5,7) tap 4 is on the outputs.
        ready = 1'b1;
        step();
        ready = 1'b0;
        for (int n = 0; n < (5 * W + 7) * 9 + 5; n++) step();
        check("mid_tap_vld", tap_vld, 1);
        check("mid_tap_idx", tap_idx, 4);
        check("mid_iaddr", iaddr, 5 * W + 7);
        reset = 1'b1;
        step();
        check_reset("mid_conv");
        reset = 1'b0;
        step();

        // Full run: random holds and ready pulses, a 3-cycle hold burst before pixel (1,1) tap 3.
        gen_expected();
        act_idx    = 0;
        busy_cnt   = 0;
        bubbles    = 0;
        progressed = 0;
        burst_left = 0;
        burst_done = 1'b0;
        mon_en     = 1'b1;
        ready      = 1'b1;
        hold       = 1'b1;
        step();
        while (progressed < BASE - 1) begin
            if (!burst_done && progressed == (W + 1) * 9 + 3) begin
                burst_left = 3;
                burst_done = 1'b1;
            end
            if (burst_left > 0) begin
                h = 1'b1;
                burst_left--;
            end else begin
                h = ($urandom_range(0, 15) == 0);
            end
            hold  = h;
            ready = 1'($urandom_range(0, 1));
            step();
            if (h) bubbles++;
            else progressed++;
        end
        hold  = 1'($urandom_range(0, 1));
        ready = 1'b0;
        step();
        hold = 1'b0;
        repeat (6) step();
        mon_en = 1'b0;

        check("busy_cycles", busy_cnt, BASE + bubbles);
        check("tap_q_left", tap_q.size(), 0);
        check("wr_q_left", wr_q.size(), 0);
        check("rd_q_left", rd_q.size(), 0);
        check("lat_q_left", lat_q.size(), 0);
        check("end_busy", busy, 0);
        check("end_csel", csel, 0);
        check("end_state", dbg_state, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog keeps the run bounded even if the DUT stalls.
    initial begin
        #900000;
        errors++;
        $display("FAIL watchdog: got timeout expected run completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
